em_reg_movz: RTL and testbench

EM_REG_MOVZ -- requirements
Module: em_reg_movz

---
 rtl/em_reg_movz.sv | 116 +++++++++++
 tb/tb_em_reg_movz.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/em_reg_movz.sv
// rtl/em_reg_movz.sv - EX/MEM pipeline register with MOVZ conditional-write resolution and taken counter
module em_reg_movz #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             flush,
    input  logic [31:0]      e_pc,
    input  logic [31:0]      e_instr,
    input  logic [31:0]      e_alu_out,
    input  logic [31:0]      e_rs_data,
    input  logic [31:0]      e_rt_data,
    input  logic [4:0]       e_wa,
    input  logic             e_regwrite,
    input  logic             e_is_movz,
    output logic [31:0]      m_pc,
    output logic [31:0]      m_instr,
    output logic [31:0]      m_alu_out,
    output logic [31:0]      m_rt_data,
    output logic [4:0]       m_wa,
    output logic             m_movz_sel,
    output logic             m_regwrite,
    output logic             m_valid,
    output logic [CNT_W-1:0] m_movz_taken_cnt
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      alu_out_q, alu_out_d;
    logic [31:0]      rt_data_q, rt_data_d;
    logic [4:0]       wa_q, wa_d;
    logic             movz_sel_q, movz_sel_d;
    logic             regwrite_q, regwrite_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic cond;
    logic movz_taken;
    logic movz_dropped;

    // A not-taken MOVZ is squashed into a non-writing op; taken and ordinary ops pass through.
    assign cond         = (e_rt_data == 32'h0);
    assign movz_taken   = e_is_movz & cond;
    assign movz_dropped = e_is_movz & ~cond;

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        alu_out_d  = alu_out_q;
        rt_data_d  = rt_data_q;
        wa_d       = wa_q;
        movz_sel_d = movz_sel_q;
        regwrite_d = regwrite_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        if (flush) begin
            pc_d       = RESET_PC;
            instr_d    = 32'h0;
            alu_out_d  = 32'h0;
            rt_data_d  = 32'h0;
            wa_d       = 5'd0;
            movz_sel_d = 1'b0;
            regwrite_d = 1'b0;
            valid_d    = 1'b0;
        end else if (en) begin
            pc_d       = e_pc;
            instr_d    = e_instr;
            alu_out_d  = e_is_movz ? e_rs_data : e_alu_out;
            rt_data_d  = e_rt_data;
            wa_d       = movz_dropped ? 5'd0 : e_wa;
            movz_sel_d = ~movz_dropped;
            regwrite_d = e_regwrite & ~movz_dropped & (e_wa != 5'd0);
            valid_d    = 1'b1;
            if (movz_taken && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            alu_out_q  <= 32'h0;
            rt_data_q  <= 32'h0;
            wa_q       <= 5'd0;
            movz_sel_q <= 1'b0;
            regwrite_q <= 1'b0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            alu_out_q  <= alu_out_d;
            rt_data_q  <= rt_data_d;
            wa_q       <= wa_d;
            movz_sel_q <= movz_sel_d;
            regwrite_q <= regwrite_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign m_pc             = pc_q;
    assign m_instr          = instr_q;
    assign m_alu_out        = alu_out_q;
    assign m_rt_data        = rt_data_q;
    assign m_wa             = wa_q;
    assign m_movz_sel       = movz_sel_q;
    assign m_regwrite       = regwrite_q;
    assign m_valid          = valid_q;
    assign m_movz_taken_cnt = cnt_q;

endmodule

// File: tb/tb_em_reg_movz.sv
// tb/tb_em_reg_movz.sv - self-checking bench for em_reg_movz against a behavioural model
module tb_em_reg_movz;

    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam int          CW  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic [31:0]   e_pc = '0, e_instr = '0, e_alu_out = '0, e_rs_data = '0, e_rt_data = '0;
    logic [4:0]    e_wa = '0;
    logic          e_regwrite = 1'b0;
    logic          e_is_movz = 1'b0;
    logic [31:0]   m_pc, m_instr, m_alu_out, m_rt_data;
    logic [4:0]    m_wa;
    logic          m_movz_sel, m_regwrite, m_valid;
    logic [CW-1:0] m_movz_taken_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] x_pc, x_instr, x_alu, x_rt;
    logic [4:0]  x_wa;
    logic        x_sel, x_rw, x_valid;
    int          x_cnt;

    em_reg_movz #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
        .e_pc(e_pc), .e_instr(e_instr), .e_alu_out(e_alu_out),
        .e_rs_data(e_rs_data), .e_rt_data(e_rt_data), .e_wa(e_wa),
        .e_regwrite(e_regwrite), .e_is_movz(e_is_movz),
        .m_pc(m_pc), .m_instr(m_instr), .m_alu_out(m_alu_out), .m_rt_data(m_rt_data),
        .m_wa(m_wa), .m_movz_sel(m_movz_sel), .m_regwrite(m_regwrite),
        .m_valid(m_valid), .m_movz_taken_cnt(m_movz_taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        x_pc = RPC; x_instr = 0; x_alu = 0; x_rt = 0; x_wa = 0;
        x_sel = 0; x_rw = 0; x_valid = 0; x_cnt = 0;
    endtask

    // Reference behaviour of one rising edge, written from the stage's rules.
    task automatic model_edge();
        bit c;
        if (!reset_n) model_reset();
        else if (flush) begin
            x_pc = RPC; x_instr = 0; x_alu = 0; x_rt = 0; x_wa = 0;
            x_sel = 0; x_rw = 0; x_valid = 0;
        end else if (en) begin
            c = (e_rt_data == 0);
            x_pc = e_pc; x_instr = e_instr; x_rt = e_rt_data; x_valid = 1;
            x_alu = e_is_movz ? e_rs_data : e_alu_out;
            if (e_is_movz) begin
                x_sel = c; x_rw = e_regwrite && c; x_wa = c ? e_wa : 5'd0;
                if (c) x_cnt = (x_cnt + 1 > 15) ? 15 : x_cnt + 1;
            end else begin
                x_sel = 1; x_rw = e_regwrite; x_wa = e_wa;
            end
            if (e_wa == 0) x_rw = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, m_pc, x_pc);
        chk({tag, ".instr"}, m_instr, x_instr);
        chk({tag, ".alu"}, m_alu_out, x_alu);
        chk({tag, ".rt"}, m_rt_data, x_rt);
        chk({tag, ".wa"}, {27'b0, m_wa}, {27'b0, x_wa});
        chk({tag, ".sel"}, {31'b0, m_movz_sel}, {31'b0, x_sel});
        chk({tag, ".rw"}, {31'b0, m_regwrite}, {31'b0, x_rw});
        chk({tag, ".valid"}, {31'b0, m_valid}, {31'b0, x_valid});
        chk({tag, ".cnt"}, {28'b0, m_movz_taken_cnt}, x_cnt);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic den, input logic dfl, input logic mz, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] alu, input logic [4:0] wa,
                         input logic rw);
        en = den; flush = dfl; e_is_movz = mz; e_rs_data = rs; e_rt_data = rt;
        e_alu_out = alu; e_wa = wa; e_regwrite = rw;
        e_pc = e_pc + 4; e_instr = $urandom;
    endtask

    initial begin
        model_reset();
        e_pc = 32'h0000_1000;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        drive(1, 0, 1, 32'hDEADBEEF, 32'h0, 32'h1111_1111, 5'd8, 1);
        tick("movz_taken");
        chk("movz_taken.alu_const", m_alu_out, 32'hDEADBEEF);
        chk("movz_taken.cnt_const", {28'b0, m_movz_taken_cnt}, 32'd1);

        drive(1, 0, 1, 32'hDEADBEEF, 32'd5, 32'h1111_1111, 5'd8, 1);
        tick("movz_not_taken");
        chk("movz_not_taken.wa_const", {27'b0, m_wa}, 32'd0);

        drive(1, 0, 0, 32'h0, 32'h0000_0042, 32'd7, 5'd3, 1);
        tick("addu");
        drive(0, 0, 1, 32'h5555_5555, 32'h0, 32'h9999_9999, 5'd9, 1);
        repeat (3) tick("stall");
        drive(0, 1, 1, 32'h5555_5555, 32'h0, 32'h9999_9999, 5'd9, 1);
        tick("flush_over_stall");
        chk("flush.pc_const", m_pc, 32'h0000_3000);

        drive(1, 0, 0, 32'h0, 32'h1, 32'h1234, 5'd0, 1);
        tick("zero_dest");
        chk("zero_dest.rw_const", {31'b0, m_regwrite}, 32'd0);

        drive(1, 1, 0, 32'h0, 32'h1, 32'h22, 5'd4, 1);
        tick("bubble");
        drive(1, 0, 0, 32'h0, 32'h1, 32'h33, 5'd4, 1);
        tick("after_bubble");

        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 1, $urandom, 32'h0, $urandom, 5'($urandom_range(1, 31)), 1);
            tick("saturate");
        end
        chk("saturate.cnt_const", {28'b0, m_movz_taken_cnt}, 32'hF);

        drive(1, 0, 0, 32'h0, 32'h7, 32'hABCD, 5'd6, 1);
        tick("pre_reset");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        drive(1, 1, 1, 32'h1, 32'h0, 32'h2, 5'd2, 1);
        tick("held_reset");
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, 1, 32'h1, 32'h0, 32'h2, 5'd2, 1);
        tick("stall_after_reset");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("reset_mid_stall");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
                  $urandom, ($urandom_range(0, 1) != 0) ? 32'h0 : $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom_range(0, 1));
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
